// File: rtl/div_iterative.sv
// div_iterative
// Sequential signed 32-bit divider for the multdiv unit. The divider works on
// operand magnitudes with a restoring algorithm and retires one quotient bit
// per clock. It fixes up the sign, the divide-by-zero result and the overflow
// result when the iterations finish.
//
// Ports
//   clock           rising-edge clock for all state
//   reset           synchronous, active-high; clears all state and outputs
//   data_operandA   dividend, two's complement; sampled when ctrl_DIV=1
//   data_operandB   divisor, two's complement; sampled when ctrl_DIV=1
//   ctrl_DIV        start pulse; a high level in any state (re)starts a division
//   data_result     signed quotient, truncated toward zero
//   data_exception  divide-by-zero or overflow flag
//   data_resultRDY  one-cycle pulse marking data_result/data_exception valid
//
// State | meaning
// IDLE  | waiting for ctrl_DIV
// RUN   | 32 shift/subtract iterations, counter 0..31
// DONE  | sign fix-up, write result, pulse data_resultRDY
module div_iterative #(
  // Only 32 is supported: the remainder datapath is WIDTH+1 = 33 bits wide.
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [4:0]       counter;
  // The partial remainder always stays below D <= 2^31, so its top bit of the
  // 33-bit remainder is structurally zero and is not stored.
  logic [WIDTH-1:0] rem_a;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   div_d;
  logic             sign_q;
  logic             div_zero;
  logic             ovf;

  // Magnitudes held in WIDTH+1 bits so |0x80000000| stays representable.
  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;
  logic [WIDTH:0] mag_a;
  logic [WIDTH:0] mag_b;

  assign ext_a = {data_operandA[WIDTH-1], data_operandA};
  assign ext_b = {data_operandB[WIDTH-1], data_operandB};
  assign mag_a = data_operandA[WIDTH-1] ? -ext_a : ext_a;
  assign mag_b = data_operandB[WIDTH-1] ? -ext_b : ext_b;

  // One restoring step: shift {A,Q} left by one, then trial-subtract D.
  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] trial;

  assign a_sh  = {rem_a, quo[WIDTH-1]};
  assign trial = a_sh - div_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      rem_a          <= '0;
      quo            <= '0;
      div_d          <= '0;
      sign_q         <= 1'b0;
      div_zero       <= 1'b0;
      ovf            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        // A start in RUN or DONE silently drops the in-flight division.
        sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        quo      <= mag_a[WIDTH-1:0];
        div_d    <= mag_b;
        rem_a    <= '0;
        div_zero <= (data_operandB == '0);
        ovf      <= (data_operandA == MIN_NEG) && (data_operandB == '1);
        counter  <= '0;
        state    <= RUN;
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            if (!trial[WIDTH]) begin
              rem_a <= trial[WIDTH-1:0];
              quo   <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem_a <= a_sh[WIDTH-1:0];
              quo   <= {quo[WIDTH-2:0], 1'b0};
            end
            counter <= counter + 5'd1;
            if (counter == 5'd31) state <= DONE;
          end
          DONE: begin
            if (div_zero) begin
              data_result <= '0;
            end else if (ovf) begin
              data_result <= MIN_NEG;
            end else begin
              data_result <= sign_q ? -quo : quo;
            end
            data_exception <= div_zero | ovf;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iterative.sv
module tb_div_iterative;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_pass  = 0;
  int n_total = 0;

  div_iterative #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Drive a one-cycle start; returns at the negedge after the start edge.
  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0BAD_F00D;
  endtask

  // Observe n edges; report the first edge index carrying RDY, how many RDYs
  // were seen, and result/exception at the first RDY.
  task automatic watch(input int n, output int first_edge, output int rdy_cnt,
                       output logic [31:0] res, output logic exc);
    first_edge = 0;
    rdy_cnt    = 0;
    res        = 'x;
    exc        = 1'bx;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) begin
        if (rdy_cnt == 0) begin
          first_edge = i;
          res        = data_result;
          exc        = data_exception;
        end
        rdy_cnt++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ctrl_DIV = 1'b1;
    data_operandA = 32'd100; data_operandB = 32'd7;
    repeat (3) @(posedge clock);
    #1;
    n_total++; if (data_result !== 32'h0) $display("FAIL reset_result got %h want 00000000", data_result); else n_pass++;
    n_total++; if (data_exception !== 1'b0) $display("FAIL reset_exc got %b want 0", data_exception); else n_pass++;
    n_total++; if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy got %b want 0", data_resultRDY); else n_pass++;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic test_basic;
    int fe, cnt; logic [31:0] r; logic e;
    pulse_start(32'd100, 32'd7);
    watch(40, fe, cnt, r, e);
    n_total++; if (fe !== 33) $display("FAIL basic_latency got %0d want 33", fe); else n_pass++;
    n_total++; if (cnt !== 1) $display("FAIL basic_rdy_count got %0d want 1", cnt); else n_pass++;
    n_total++; if (r !== 32'd14) $display("FAIL basic_result got %h want 0000000e", r); else n_pass++;
    n_total++; if (e !== 1'b0) $display("FAIL basic_exc got %b want 0", e); else n_pass++;
    n_total++; if (data_result !== 32'd14) $display("FAIL basic_hold got %h want 0000000e", data_result); else n_pass++;
  endtask

  task automatic test_signs;
    logic [31:0] va [4] = '{32'hFFFF_FF9C, 32'd100,      32'hFFFF_FF9C, 32'hFFFF_FFF9};
    logic [31:0] vb [4] = '{32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
    logic [31:0] vq [4] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14,        32'd0};
    int fe, cnt; logic [31:0] r; logic e;
    for (int k = 0; k < 4; k++) begin
      pulse_start(va[k], vb[k]);
      watch(34, fe, cnt, r, e);
      n_total++; if (fe !== 33 || r !== vq[k]) $display("FAIL signs_%0d got edge %0d res %h want edge 33 res %h", k, fe, r, vq[k]); else n_pass++;
      n_total++; if (e !== 1'b0) $display("FAIL signs_exc_%0d got %b want 0", k, e); else n_pass++;
    end
  endtask

  task automatic test_exceptions;
    logic [31:0] va [3] = '{32'd12345, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb [3] = '{32'd0,     32'hFFFF_FFFF, 32'd1};
    logic [31:0] vq [3] = '{32'd0,     32'h8000_0000, 32'h8000_0000};
    logic        ve [3] = '{1'b1,      1'b1,          1'b0};
    int fe, cnt; logic [31:0] r; logic e;
    for (int k = 0; k < 3; k++) begin
      pulse_start(va[k], vb[k]);
      watch(34, fe, cnt, r, e);
      n_total++; if (fe !== 33 || cnt !== 1) $display("FAIL exc_latency_%0d got edge %0d count %0d want 33 1", k, fe, cnt); else n_pass++;
      n_total++; if (r !== vq[k] || e !== ve[k]) $display("FAIL exc_result_%0d got %h/%b want %h/%b", k, r, e, vq[k], ve[k]); else n_pass++;
    end
  endtask

  task automatic test_boundaries;
    logic [31:0] va [3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd5};
    logic [31:0] vb [3] = '{32'd1,         32'h7FFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] vq [3] = '{32'h7FFF_FFFF, 32'd1,         32'd0};
    int fe, cnt; logic [31:0] r; logic e;
    for (int k = 0; k < 3; k++) begin
      pulse_start(va[k], vb[k]);
      watch(34, fe, cnt, r, e);
      n_total++; if (fe !== 33 || r !== vq[k] || e !== 1'b0) $display("FAIL bound_%0d got edge %0d %h/%b want 33 %h/0", k, fe, r, e, vq[k]); else n_pass++;
    end
  endtask

  task automatic test_restart;
    int fe, cnt; logic [31:0] r; logic e;
    pulse_start(32'd1000, 32'd3);
    watch(9, fe, cnt, r, e);
    pulse_start(32'd81, 32'd9);
    watch(40, fe, cnt, r, e);
    n_total++; if (fe !== 33) $display("FAIL restart_latency got %0d want 33", fe); else n_pass++;
    n_total++; if (cnt !== 1) $display("FAIL restart_rdy_count got %0d want 1", cnt); else n_pass++;
    n_total++; if (r !== 32'd9 || e !== 1'b0) $display("FAIL restart_result got %h/%b want 00000009/0", r, e); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int fe, cnt; logic [31:0] r; logic e;
    pulse_start(32'd1000, 32'd3);
    watch(19, fe, cnt, r, e);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_total++; if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0)
      $display("FAIL abort_outputs got %h/%b/%b want 00000000/0/0", data_result, data_exception, data_resultRDY);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    watch(40, fe, cnt, r, e);
    n_total++; if (cnt !== 0) $display("FAIL abort_no_rdy got %0d want 0", cnt); else n_pass++;
    pulse_start(32'd1000, 32'd3);
    watch(34, fe, cnt, r, e);
    n_total++; if (fe !== 33 || r !== 32'd333 || e !== 1'b0) $display("FAIL abort_fresh got edge %0d %h/%b want 33 0000014d/0", fe, r, e); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    test_reset();
    test_basic();
    test_signs();
    test_exceptions();
    test_boundaries();
    test_restart();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
